// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch stage: imem req/gnt/rvalid, in-order queue, redirect flush
// Optional perf counters perf_fetched/perf_bubble when IFQ_PERF_CNT_EN is defined.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall_in,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc_if2id,
  output logic [4:0]  wr_addr,
  output logic        ide_wait
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubble
`endif
);

  localparam int          PW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int          CW  = $clog2(QDEPTH + 1);
  localparam logic [CW:0] QD  = (CW+1)'(QDEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

  state_t          state;
  logic [31:0]     fetch_pc;
  logic [31:0]     resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   q_count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            out_valid;
  logic [31:0]     q_data [QDEPTH];
  logic [31:0]     q_pc   [QDEPTH];

  logic            issue;
  logic            accept;
  logic            advance;
  logic            pop;
  logic            q_pop;
  logic            q_write;
  logic [CW:0]     inflight;
  logic [CW-1:0]   out_next;
  logic [CW-1:0]   drop_next;
  logic [31:0]     head_data;
  logic [31:0]     head_pc;
  logic [31:0]     target;
  logic            unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];
  assign target         = {redirect_pc[31:2], 2'b00};

  // Queue slots are reserved at request time, so a granted word always has room.
  assign inflight  = {1'b0, outstanding} + {1'b0, q_count};
  assign imem_req  = (state == RUN) && !redirect_en && (inflight < QD);
  assign imem_addr = fetch_pc;
  assign issue     = imem_req && imem_gnt;
  assign out_next  = outstanding + CW'(issue) - CW'(imem_rvalid);
  assign drop_next = (imem_rvalid && drop != '0) ? drop - 1'b1 : drop;

  assign accept    = imem_rvalid && (drop == '0) && !redirect_en;
  assign advance   = !out_valid || !stall_in;
  assign pop       = advance && !redirect_en && ((q_count != '0) || accept);
  assign q_pop     = pop && (q_count != '0);
  // An empty queue lets the returning word go straight into the decode register.
  assign q_write   = accept && !(pop && q_count == '0);
  assign head_data = (q_count != '0) ? q_data[rd_ptr] : imem_rdata;
  assign head_pc   = (q_count != '0) ? q_pc[rd_ptr]   : resp_pc;

  assign ide_wait  = !out_valid || stall_in;

  always_ff @(posedge clk) begin
    if (q_write) begin
      q_data[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]   <= resp_pc;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      q_count     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      out_valid   <= 1'b0;
      instr       <= NOP;
      pc_if2id    <= '0;
      wr_addr     <= '0;
    end else begin
      outstanding <= out_next;
      if (redirect_en) begin
        // Everything still in flight belongs to the old path and is dropped on return.
        fetch_pc  <= target;
        resp_pc   <= target;
        drop      <= out_next;
        q_count   <= '0;
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        out_valid <= 1'b0;
        instr     <= NOP;
        wr_addr   <= '0;
        state     <= (out_next != '0) ? DRAIN : RUN;
      end else begin
        if (issue)   fetch_pc <= fetch_pc + 32'd4;
        if (accept)  resp_pc  <= resp_pc + 32'd4;
        if (q_write) wr_ptr   <= wr_ptr + 1'b1;
        if (q_pop)   rd_ptr   <= rd_ptr + 1'b1;
        drop    <= drop_next;
        q_count <= q_count + CW'(q_write) - CW'(q_pop);
        if (advance) begin
          if (pop) begin
            instr     <= head_data;
            pc_if2id  <= head_pc;
            wr_addr   <= head_data[11:7];
            out_valid <= 1'b1;
          end else begin
            instr     <= NOP;
            wr_addr   <= '0;
            out_valid <= 1'b0;
          end
        end
        case (state)
          BOOT:    state <= RUN;
          DRAIN:   if (drop_next == '0) state <= RUN;
          default: state <= RUN;
        endcase
      end
    end
  end

`ifdef IFQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_fetched <= '0;
      perf_bubble  <= '0;
    end else begin
      if (pop) perf_fetched <= perf_fetched + 32'd1;
      if (!out_valid && !stall_in && state != BOOT) perf_bubble <= perf_bubble + 32'd1;
    end
  end
`endif

  assert property (@(posedge clk) disable iff (!rstn) imem_rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - scoreboard bench for ifetch_queue with an in-order memory model
module tb_ifetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall_in;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc_if2id;
  logic [4:0]  wr_addr;
  logic        ide_wait;

  always #5 clk = ~clk;

  ifetch_queue #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rstn(rstn), .stall_in(stall_in),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .pc_if2id(pc_if2id), .wr_addr(wr_addr), .ide_wait(ide_wait)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend [$];
  logic [31:0] exp_q [$];
  logic [31:0] exp_fetch;
  int          outst;
  int          cyc;
  int          lat;
  bit          lat_rand;
  int          gnt_mode;
  bit          prev_pending;
  logic [31:0] prev_addr;
  int          n_cmp;
  int          n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F93;
  endfunction

  // Memory model and scoreboard: observe each cycle at negedge, drive next cycle at posedge+1.
  initial begin
    logic [31:0] p;
    logic [31:0] w;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    cyc = 0; outst = 0; exp_fetch = RESET_PC; prev_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        pend.delete();
        exp_q.delete();
        exp_fetch    = RESET_PC;
        outst        = 0;
        prev_pending = 1'b0;
      end else begin
        if (!ide_wait) begin
          if (exp_q.size() == 0) begin
            check("dec_unexpected_pc", pc_if2id, 32'hFFFF_FFFF);
          end else begin
            p = exp_q.pop_front();
            w = mem_word(p);
            check("dec_pc", pc_if2id, p);
            check("dec_instr", instr, w);
            check("dec_wr_addr", 32'(wr_addr), 32'(w[11:7]));
          end
        end
        if (prev_pending && !redirect_en) begin
          check("req_hold", 32'(imem_req), 32'd1);
          check("addr_hold", imem_addr, prev_addr);
        end
        if (redirect_en) check("req_in_redirect", 32'(imem_req), 32'd0);
        if (imem_rvalid) outst--;
        if (imem_req && imem_gnt) begin
          check("imem_addr", imem_addr, exp_fetch);
          exp_fetch = exp_fetch + 32'd4;
          outst++;
          pend.push_back('{addr: imem_addr, due: cyc + (lat_rand ? int'($urandom_range(1, 3)) : lat)});
          exp_q.push_back(imem_addr);
        end
        if (redirect_en) begin
          exp_q.delete();
          exp_fetch = {redirect_pc[31:2], 2'b00};
        end
        prev_pending = imem_req && !imem_gnt;
        prev_addr    = imem_addr;
        if (outst > QDEPTH) check("outstanding_max", 32'(outst), 32'(QDEPTH));
      end
      @(posedge clk);
      #1;
      cyc++;
      imem_gnt = (gnt_mode == 1) ? 1'b1 : (gnt_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rstn && pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr"}, instr, NOP);
    check({tag, "_pc"}, pc_if2id, 32'h0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'h0);
    check({tag, "_req"}, 32'(imem_req), 32'h0);
    check({tag, "_ide_wait"}, 32'(ide_wait), 32'h1);
  endtask

  // Called right after rstn rises at posedge+1; cycle 0 is the BOOT cycle.
  task automatic check_first_instr(input string tag);
    int first;
    first = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (!ide_wait) begin
        first = k;
        break;
      end
    end
    check({tag, "_first_cycle"}, 32'(first), 32'd3);
    check({tag, "_first_pc"}, pc_if2id, RESET_PC);
  endtask

  task automatic wait_decode(input string tag, input logic [31:0] exp_pc);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!ide_wait) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_seen"}, 32'(ok), 32'd1);
    if (ok) check(tag, pc_if2id, exp_pc);
  endtask

  // Returns at posedge+2 of a cycle in which outst == n and rvalid matches want_rv.
  task automatic wait_state(input string tag, input int n, input bit want_rv);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #2;
      if (outst == n && imem_rvalid == want_rv) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_reached"}, 32'(ok), 32'd1);
  endtask

  task automatic pulse_redirect(input logic [31:0] tgt);
    redirect_pc = tgt;
    redirect_en = 1'b1;
    @(posedge clk);
    #1;
    redirect_en = 1'b0;
  endtask

  initial begin
    logic [31:0] held_pc;
    logic [31:0] held_instr;
    logic [31:0] wrap_exp [3];
    int          rv;
    int          got_n;
    n_cmp = 0; n_bad = 0;
    rstn = 1'b0; stall_in = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
    gnt_mode = 1; lat = 1; lat_rand = 1'b0;
    wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC; wrap_exp[2] = 32'h0000_0000;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rstn = 1'b1;
    check_first_instr("boot");
    repeat (20) begin
      @(negedge clk);
      check("stream_ide_wait", 32'(ide_wait), 32'd0);
    end

    @(posedge clk);
    #1;
    stall_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        held_pc    = pc_if2id;
        held_instr = instr;
      end else begin
        check("stall_pc", pc_if2id, held_pc);
        check("stall_instr", instr, held_instr);
      end
      check("stall_ide_wait", 32'(ide_wait), 32'd1);
    end
    @(posedge clk);
    #1;
    stall_in = 1'b0;
    repeat (10) @(posedge clk);

    lat = 6;
    wait_state("redir103", 2, 1'b0);
    pulse_redirect(32'h0000_0103);
    lat = 1;
    rv = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (imem_req) break;
      if (imem_rvalid) rv++;
    end
    check("drain_rvalids", 32'(rv), 32'd2);
    check("drain_next_addr", imem_addr, 32'h0000_0100);
    wait_decode("redir103_first_pc", 32'h0000_0100);

    repeat (6) @(posedge clk);
    wait_state("coincident", 1, 1'b1);
    pulse_redirect(32'h0000_0200);
    wait_decode("coincident_first_pc", 32'h0000_0200);

    repeat (4) @(posedge clk);
    #2;
    pulse_redirect(32'hFFFF_FFF8);
    got_n = 0;
    for (int k = 0; k < 40 && got_n < 3; k++) begin
      @(negedge clk);
      if (!ide_wait) begin
        check("wrap_pc", pc_if2id, wrap_exp[got_n]);
        got_n++;
      end
    end
    check("wrap_count", 32'(got_n), 32'd3);

    gnt_mode = 2;
    lat_rand = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      stall_in    = ($urandom_range(0, 3) == 0);
      redirect_en = ($urandom_range(0, 24) == 0);
      if (redirect_en) redirect_pc = $urandom();
    end
    @(posedge clk);
    #1;
    stall_in = 1'b0; redirect_en = 1'b0;
    gnt_mode = 1; lat_rand = 1'b0; lat = 6;

    wait_state("midreset", 2, 1'b0);
    rstn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    lat = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    check_first_instr("reboot");
    repeat (10) @(posedge clk);

    #1;
    gnt_mode = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && pend.size() == 0) break;
    end
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
